// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback and a queued MDU result FIFO.
// Optional WB_ARB_PENDING_MASK_EN adds pending_mask (rd bits of queued MDU results).
module wb_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_wb_valid,
    input  logic [4:0]      pipe_wb_rd,
    input  logic [XLEN-1:0] pipe_wb_data,
    output logic            pipe_wb_ready,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    output logic            mdu_ready,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
`ifdef WB_ARB_PENDING_MASK_EN
    output logic [31:0]     pending_mask,
`endif
    output logic            mdu_busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [4:0]      fifo_rd   [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve_cnt;
    logic            push, pop, force_mdu, grant_pipe;
    logic [4:0]      g_rd;
    logic [XLEN-1:0] g_data;
    assign mdu_ready     = count < CW'(DEPTH);
    assign mdu_busy      = count != '0;
    assign push          = mdu_valid & mdu_ready;
    assign force_mdu     = mdu_busy & (starve_cnt == SW'(STARVE_MAX));
    assign pipe_wb_ready = !force_mdu;
    assign pop           = mdu_busy & (force_mdu | !pipe_wb_valid);
    assign grant_pipe    = pipe_wb_valid & !pop;
    assign g_rd          = pop ? fifo_rd[rptr] : pipe_wb_rd;
    assign g_data        = pop ? fifo_data[rptr] : pipe_wb_data;
    // Payload storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wptr]   <= mdu_rd;
            fifo_data[wptr] <= mdu_data;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            wptr       <= push ? wptr + PW'(1) : wptr;
            rptr       <= pop ? rptr + PW'(1) : rptr;
            count      <= count + CW'(push) - CW'(pop);
            starve_cnt <= (pop | !mdu_busy) ? '0 :
                          (grant_pipe && starve_cnt != SW'(STARVE_MAX)) ? starve_cnt + SW'(1) : starve_cnt;
            rf_we      <= (pop | grant_pipe) & (g_rd != 5'd0);
            if (pop | grant_pipe) begin
                rf_waddr <= g_rd;
                rf_wdata <= g_data;
            end
        end
    end
`ifdef WB_ARB_PENDING_MASK_EN
    always_comb begin
        pending_mask = '0;
        for (int k = 0; k < DEPTH; k++)
            if (CW'(k) < count) pending_mask[fifo_rd[rptr + PW'(k)]] = 1'b1;
        pending_mask[0] = 1'b0;
    end
`endif
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (the output of the writeback data select) and the multi-cycle multiply/divide unit (MDU).
- MDU results are queued in a small FIFO.
- The pipeline has default priority. A starvation counter forces an MDU drain slot by stalling the pipeline writeback for one cycle.
- Register-file write outputs are registered, with 1-cycle latency from grant.

Parameters:
XLEN, 32, data width of the write port
DEPTH, 2, MDU result FIFO entries (power of two, >=2)
STARVE_MAX, 4, consecutive pipeline wins over a non-empty FIFO before a forced MDU grant

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
pipe_wb_valid  in  1  pipeline has a writeback this cycle
pipe_wb_rd  in  5  pipeline destination register
pipe_wb_data  in  XLEN  pipeline writeback data
pipe_wb_ready  out  1  arbiter accepts the pipeline writeback; 0 = pipeline must stall
mdu_valid  in  1  MDU result available
mdu_rd  in  5  MDU destination register
mdu_data  in  XLEN  MDU result
mdu_ready  out  1  FIFO can accept an MDU result
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  5  register-file write address (registered)
rf_wdata  out  XLEN  register-file write data (registered)
mdu_busy  out  1  FIFO non-empty

Behaviour:
- Reset (async, immediate):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty (count=0, pointers 0), starve_cnt=0.
  - Resulting outputs: mdu_busy=0, mdu_ready=1, pipe_wb_ready=1.
  - Reset mid-operation discards all queued MDU results.
- FIFO push:
  - mdu_ready = (count < DEPTH), a function of registered state only.
  - Push occurs when mdu_valid & mdu_ready and stores {mdu_rd, mdu_data}.
  - There is no bypass: an entry pushed in cycle N can be granted at the earliest in N+1, and rf_we is visible in N+2.
  - When full, mdu_ready=0 and the MDU holds its result. Push and pop in the same cycle is legal whenever count<DEPTH (count unchanged).
- force = mdu_busy & (starve_cnt == STARVE_MAX).
- pipe_wb_ready = !force.
- Grant, decided combinationally each cycle:
  - FIFO empty: grant pipe if pipe_wb_valid, else idle.
  - FIFO non-empty and (force or !pipe_wb_valid): grant FIFO head (pop).
  - Otherwise: grant pipe.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when pipe is granted while FIFO is non-empty.
  - Clears on any FIFO grant.
  - Clears when the FIFO becomes empty.
  - Holds otherwise.
- Output register, next cycle after a grant:
  - rf_we = 1 iff a grant occurred and the granted rd != 0.
  - rf_waddr and rf_wdata take the granted rd and data.
  - Writes to x0 are consumed (popped or accepted) but produce rf_we=0.
  - With no grant, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
- Pipeline stalled cycle (force=1 with pipe_wb_valid=1): the pipeline must hold pipe_wb_* stable, and that writeback is granted next cycle (counter cleared).
- Ordering: a given source is written in arrival order. Cross-source WAW ordering is the issue logic's responsibility (it must not issue a pipeline write to an rd pending in the FIFO).

Optional Feature:
WB_ARB_PENDING_MASK_EN
- Defined: adds output pending_mask [31:0], combinational from FIFO state.
  - Bit i=1 iff some valid FIFO entry has rd==i, for i in 1..31.
  - Bit 0 is always 0.
  - Used by hazard detection to stall readers of in-flight MDU results.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then idle, with rst pulsed asynchronously mid-cycle:
  - Expect rf_we=0, rf_waddr=0, rf_wdata=0, mdu_ready=1, pipe_wb_ready=1, mdu_busy=0 immediately.
- Pipe only: pipe_wb_valid=1, rd=5, data=0x12345678 in cycle N.
  - Expect rf_we=1, rf_waddr=5, rf_wdata=0x12345678 in N+1.
  - Same with rd=0: expect rf_we=0.
- MDU only: push rd=7, data=0xDEADBEEF in N with the pipeline idle.
  - Expect mdu_busy=1 in N+1 and rf_we=1, waddr=7, wdata=0xDEADBEEF in N+2, then mdu_busy=0.
- Starvation: one queued MDU entry (rd=9), pipe_wb_valid held high for 8 cycles.
  - Expect 4 pipe grants, then 1 cycle with pipe_wb_ready=0 and rf_waddr=9 written.
  - Then pipe grants resume with the stalled pipe writeback written next.
- Full FIFO: push 2 entries while the pipe is continuously valid.
  - Expect mdu_ready=0 with the third mdu_valid held.
  - After a forced pop, mdu_ready=1 and the third result is accepted, with FIFO order preserved (rd 1,2,3).
- WB_ARB_PENDING_MASK_EN: queue rd=3 and rd=0.
  - Expect pending_mask=0x00000008, then 0 after both drain.
  - Reset mid-queue clears the mask immediately.
